// File: rtl/cm3_log_arb.sv
// cm3_log_arb: round-robin sequencer sharing one log core between NREQ
// requesters. One operation in flight; the result is routed back to the
// requester that issued it.
// Optional feature macro: CM3_LOG_ARB_TIMEOUT_EN -- aborts a WAIT that lasts
// TIMEOUT cycles and answers the owner with resp_err=1, data 32'hFFFF_FFFF.
module cm3_log_arb #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 hclk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      resp_valid,
   output logic [31:0]          resp_data,
   output logic                 resp_err,
   output logic                 busy,
   output logic                 stray_seen,
   output logic [31:0]          data_a,
   output logic                 data_a_valid,
   input  logic [31:0]          data_log,
   input  logic                 data_log_valide
);

   localparam int LW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t          state, state_nxt;
   logic [LW-1:0]   last_grant;
   logic [LW-1:0]   gid;
   logic [LW-1:0]   pick;
   logic            found;
   logic [NREQ-1:0] pick_oh;
   logic [NREQ-1:0] gid_oh;
   logic            done_ok;
   logic            tmo_hit;
   logic [LW:0]     rr_sum;

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_cfg
      $error("cm3_log_arb: NREQ must be 2..8 and TIMEOUT 2..256");
   end

   // Round-robin search: first valid requester after last_grant, wrapping.
   always_comb begin
      found  = 1'b0;
      pick   = '0;
      rr_sum = '0;
      for (int k = 1; k <= NREQ; k++) begin
         rr_sum = {1'b0, last_grant} + (LW+1)'(k);
         if (rr_sum >= (LW+1)'(NREQ)) rr_sum = rr_sum - (LW+1)'(NREQ);
         if (!found && req_valid[rr_sum[LW-1:0]]) begin
            found = 1'b1;
            pick  = rr_sum[LW-1:0];
         end
      end
   end

   assign pick_oh = found ? ({{(NREQ-1){1'b0}}, 1'b1} << pick) : '0;
   assign gid_oh  = {{(NREQ-1){1'b0}}, 1'b1} << gid;
   assign done_ok = (state == S_WAIT) && data_log_valide;

`ifdef CM3_LOG_ARB_TIMEOUT_EN
   logic [7:0] wcnt;
   logic       err_q;

   // WAIT-cycle counter, restarted every time WAIT is entered.
   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n)                wcnt <= '0;
      else if (state == S_ISSUE) wcnt <= '0;
      else if (state == S_WAIT)  wcnt <= wcnt + 8'd1;
   end

   // A result arriving in the timeout cycle still wins.
   assign tmo_hit  = (state == S_WAIT) && !data_log_valide && (wcnt == 8'(TIMEOUT-1));
   assign resp_err = err_q;
`else
   assign tmo_hit  = 1'b0;
   assign resp_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state: accept -> issue -> wait for result (or timeout).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (found) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (done_ok || tmo_hit) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from state; accept pulse only while idle.
   always_comb begin
      req_ready    = '0;
      data_a_valid = 1'b0;
      busy         = 1'b0;
      case (state)
         S_IDLE:  req_ready = pick_oh;
         S_ISSUE: begin
            data_a_valid = 1'b1;
            busy         = 1'b1;
         end
         S_WAIT:  busy = 1'b1;
         default: ;
      endcase
   end

   // Operand latch, result return, fairness pointer and stray tracking.
   always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= LW'(NREQ-1);
         gid        <= '0;
         data_a     <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         stray_seen <= 1'b0;
`ifdef CM3_LOG_ARB_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         resp_valid <= '0;
         if (state == S_IDLE && found) begin
            gid    <= pick;
            data_a <= req_data[32*pick +: 32];
         end
         if (done_ok) begin
            resp_valid <= gid_oh;
            resp_data  <= data_log;
            last_grant <= gid;
`ifdef CM3_LOG_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
         end else if (tmo_hit) begin
            resp_valid <= gid_oh;
            resp_data  <= 32'hFFFF_FFFF;
            last_grant <= gid;
`ifdef CM3_LOG_ARB_TIMEOUT_EN
            err_q      <= 1'b1;
`endif
         end
         if (data_log_valide && state != S_WAIT) stray_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cm3_log_arb.sv
// Directed bench for cm3_log_arb: an operation-level model (round-robin pick,
// one outstanding op, result one cycle after the core strobe) is checked on
// every cycle, plus literal latency/order checks for the directed scenarios.
module tb_cm3_log_arb;
   localparam int NREQ = 2;
   localparam int TMO  = 64;

   logic               hclk, rst_n;
   logic [NREQ-1:0]    req_valid, req_ready, resp_valid;
   logic [32*NREQ-1:0] req_data;
   logic [31:0]        resp_data, data_a, data_log;
   logic               resp_err, busy, stray_seen, data_a_valid, data_log_valide;

   cm3_log_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .hclk(hclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_err(resp_err), .busy(busy), .stray_seen(stray_seen), .data_a(data_a),
      .data_a_valid(data_a_valid), .data_log(data_log), .data_log_valide(data_log_valide)
   );

   int total = 0, bad = 0, cyc = 0;
   int rq_add[NREQ], rq_done[NREQ];
   logic [31:0] rq_base[NREQ];
   int core_en = 1, core_dly = 3, core_cnt = 0;
   logic [31:0] core_res;
   int stray_req_n = 0, stray_done = 0;
   int gq[$], gcyc[$], rcyc[$], rid[$], rerr[$];
   logic [31:0] rdat[$];
   int icyc = 0;
   logic [31:0] idata = '0;

   initial begin
      hclk = 0;
      forever #5 hclk = ~hclk;
   end

   initial forever begin
      @(posedge hclk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   // Requesters: operand k of requester i is base + 0x100*k; drop after accept.
   initial begin
      logic [NREQ-1:0] acc;
      for (int i = 0; i < NREQ; i++) begin
         rq_done[i] = 0;
      end
      req_valid = '0;
      req_data  = '0;
      forever begin
         @(negedge hclk);
         acc = req_ready;
         @(posedge hclk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && rq_add[i] > rq_done[i]) rq_done[i]++;
            req_valid[i] = rq_add[i] > rq_done[i];
            req_data[32*i +: 32] = rq_base[i] + 32'h100 * rq_done[i];
         end
      end
   end

   // Log core stand-in: answers (x*21)>>1 core_dly cycles after the start strobe.
   initial begin
      data_log_valide = 0;
      data_log = '0;
      forever begin
         @(negedge hclk);
         if (core_en != 0 && data_a_valid) begin
            core_cnt = core_dly;
            core_res = (data_a * 32'd21) >> 1;
         end
         @(posedge hclk);
         #1;
         data_log_valide = 0;
         if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               data_log_valide = 1;
               data_log = core_res;
            end
         end
         if (stray_req_n != stray_done) begin
            stray_done = stray_req_n;
            data_log_valide = 1;
            data_log = 32'hDEAD_0000;
         end
      end
   end

   // Operation-level model and per-cycle compare.
   initial begin
      bit m_out, m_issue, m_rsp, m_stray;
      int m_id, m_last, m_rid, m_wcnt, g;
      logic [31:0] m_op, m_rdata;
      logic m_rerr;
      logic [NREQ-1:0] er;
      m_out = 0; m_issue = 0; m_rsp = 0; m_stray = 0; m_last = NREQ-1;
      m_id = 0; m_rid = 0; m_wcnt = 0; m_op = '0; m_rdata = '0; m_rerr = 0;
      forever begin
         @(negedge hclk);
         if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_err", 32'(resp_err), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_stray", 32'(stray_seen), 0);
            chk("rst_data_a", data_a, 0);
            chk("rst_data_a_valid", 32'(data_a_valid), 0);
            m_out = 0; m_issue = 0; m_rsp = 0; m_stray = 0; m_last = NREQ-1;
            continue;
         end
         g  = m_out ? -1 : rr_pick(req_valid, m_last);
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(er));
         chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
         chk("data_a_valid", 32'(data_a_valid), 32'(m_issue));
         if (m_issue) chk("data_a", data_a, m_op);
         chk("busy", 32'(busy), 32'(m_out));
         er = '0;
         if (m_rsp) er[m_rid] = 1'b1;
         chk("resp_valid", 32'(resp_valid), 32'(er));
         if (m_rsp) begin
            chk("resp_data", resp_data, m_rdata);
            chk("resp_err", 32'(resp_err), 32'(m_rerr));
         end
         chk("stray_seen", 32'(stray_seen), 32'(m_stray));
         // logs for the directed literal checks
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin gq.push_back(i); gcyc.push_back(cyc); end
            if (resp_valid[i]) begin
               rcyc.push_back(cyc); rid.push_back(i);
               rdat.push_back(resp_data); rerr.push_back(int'(resp_err));
            end
         end
         if (data_a_valid) begin icyc = cyc; idata = data_a; end
         // advance to next cycle
         m_rsp = 0;
         if (m_out && !m_issue) begin
            if (data_log_valide) begin
               m_rsp = 1; m_rid = m_id; m_rdata = data_log; m_rerr = 0;
               m_out = 0; m_last = m_id;
            end
`ifdef CM3_LOG_ARB_TIMEOUT_EN
            else if (m_wcnt == TMO-1) begin
               m_rsp = 1; m_rid = m_id; m_rdata = 32'hFFFF_FFFF; m_rerr = 1;
               m_out = 0; m_last = m_id;
            end
`endif
            else m_wcnt++;
         end else if (data_log_valide) m_stray = 1;
         m_issue = 0;
         if (g >= 0) begin
            m_out = 1; m_issue = 1; m_id = g; m_wcnt = 0;
            m_op = req_data[32*g +: 32];
         end
      end
   end

   task automatic wait_resp(input int n, input string nm);
      int b = 0;
      while (rcyc.size() < n && b < 400) begin
         @(posedge hclk);
         b++;
      end
      if (rcyc.size() < n) begin
         total++; bad++;
         $display("FAIL %s: responses %0d want %0d before cycle budget", nm, rcyc.size(), n);
      end
   endtask

   task automatic wait_issue(output int c);
      c = -1;
      for (int b = 0; b < 100; b++) begin
         @(negedge hclk);
         if (data_a_valid) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         total++; bad++;
         $display("FAIL wait_issue: data_a_valid never seen want 1");
      end
   endtask

   task automatic do_reset();
      @(posedge hclk);
      #2 rst_n = 0;
      @(posedge hclk);
      #2 rst_n = 1;
   endtask

   initial begin
      int c, n0, ta;
      for (int i = 0; i < NREQ; i++) begin
         rq_add[i] = 0;
         rq_base[i] = '0;
      end
      rst_n = 0;
      repeat (3) @(posedge hclk);
      #2 rst_n = 1;

      // 1: single op from requester 0
      @(posedge hclk);
      rq_base[0] = 32'h0000_0400;
      rq_add[0]++;
      wait_resp(1, "t1_resp");
      @(negedge hclk);
      ta = gcyc[$];
      chk("t1_grant", 32'(gq[$]), 0);
      chk("t1_issue_lat", 32'(icyc - ta), 1);
      chk("t1_data_a", idata, 32'h0000_0400);
      chk("t1_resp_lat", 32'(rcyc[$] - ta), 5);
      chk("t1_resp_id", 32'(rid[$]), 0);
      chk("t1_resp_data", rdat[$], 32'h0000_2A00);
      chk("t1_resp_err", 32'(rerr[$]), 0);

      // 2: both requesters continuously valid -> 0,1,0,1
      do_reset();
      @(posedge hclk);
      rq_base[0] = 32'h0000_1000;
      rq_base[1] = 32'h0000_2000;
      rq_add[0] += 2;
      rq_add[1] += 2;
      n0 = gq.size();
      wait_resp(rcyc.size() + 4, "t2_resp");
      @(negedge hclk);
      chk("t2_grants", 32'(gq.size() - n0), 4);
      if (gq.size() >= n0 + 4) begin
         chk("t2_order0", 32'(gq[n0]), 0);
         chk("t2_order1", 32'(gq[n0+1]), 1);
         chk("t2_order2", 32'(gq[n0+2]), 0);
         chk("t2_order3", 32'(gq[n0+3]), 1);
      end

      // 3: stray result in IDLE, then a normal request
      @(posedge hclk);
      n0 = rcyc.size();
      stray_req_n++;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      chk("t3_stray", 32'(stray_seen), 1);
      chk("t3_no_resp", 32'(rcyc.size()), 32'(n0));
      @(posedge hclk);
      rq_add[1]++;
      wait_resp(n0 + 1, "t3_resp");
      @(negedge hclk);
      chk("t3_resp_id", 32'(rid[$]), 1);

      // 6: result strobe coincides with req_valid[1] rising
      @(posedge hclk);
      rq_add[0]++;
      wait_issue(c);
      repeat (3) @(posedge hclk);
      rq_add[1]++;
      n0 = rcyc.size();
      wait_resp(n0 + 2, "t6_resp");
      @(negedge hclk);
      chk("t6_first_id", 32'(rid[n0]), 0);
      chk("t6_resp_cyc", 32'(rcyc[n0] - c), 4);
      chk("t6_ready1_id", 32'(gq[gq.size()-1]), 1);
      chk("t6_ready1_cyc", 32'(gcyc[gcyc.size()-1]), 32'(rcyc[n0]));

      // 4: reset while requester 1 is in WAIT; late result becomes stray
      @(posedge hclk);
      rq_add[1]++;
      wait_issue(c);
      n0 = rcyc.size();
      @(posedge hclk);
      #2 rst_n = 0;
      @(posedge hclk);
      #2 rst_n = 1;
      repeat (5) @(posedge hclk);
      @(negedge hclk);
      chk("t4_stray", 32'(stray_seen), 1);
      chk("t4_no_resp", 32'(rcyc.size()), 32'(n0));
      chk("t4_busy", 32'(busy), 0);

`ifdef CM3_LOG_ARB_TIMEOUT_EN
      // 5: core never answers -> timeout response 64 cycles after WAIT entry
      @(posedge hclk);
      core_en = 0;
      rq_add[0]++;
      wait_issue(c);
      n0 = rcyc.size();
      wait_resp(n0 + 1, "t5_resp");
      @(negedge hclk);
      chk("t5_resp_cyc", 32'(rcyc[$] - (c + 1)), 64);
      chk("t5_resp_err", 32'(rerr[$]), 1);
      chk("t5_resp_data", rdat[$], 32'hFFFF_FFFF);
      chk("t5_busy_after", 32'(busy), 0);
      core_en = 1;
`endif

      repeat (3) @(posedge hclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
